gmii_tx_outgoing: RTL and testbench
===================================

# gmii_tx_outgoing

- Transmit-side GMII framer in the `clk_125m` domain; the outbound counterpart of the PHY receive path.
- Takes raw Ethernet frame bytes (destination MAC through end of payload) from the UDP/GPSDO packet builder over a valid/ready byte stream.
- Drives the PHY GMII transmit pins directly. It inserts preamble and SFD, zero-pads short frames to the 60-byte minimum, appends the IEEE 802.3 FCS, and enforces the inter-frame gap.

## Interface
Parameters:
- `IFG_CYCLES`, default 12: minimum idle cycles between frames on `phy_tx_en`.
- `MIN_LEN`, default 60: minimum payload+pad length in bytes before FCS.

Ports:
- `clk_125m`  in  1  Single clock; also the GMII GTX clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `tx_dat`  in  8  Frame byte from upstream.
- `tx_vd`  in  1  `tx_dat` valid.
- `tx_last`  in  1  Marks the final payload byte; qualified by `tx_vd`.
- `tx_rdy`  out  1  Byte accepted on any edge where `tx_vd & tx_rdy`.
- `tx_busy`  out  1  High from frame start through the end of IFG.
- `tx_underrun`  out  1  One-cycle pulse when a frame is aborted.
- `phy_tx_en`  out  1  GMII TX_EN; IOB register.
- `phy_tx_er`  out  1  GMII TX_ER; IOB register.
- `phy_txd`  out  8  GMII TXD; IOB register.

## Operation
- FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- **IDLE:** `tx_rdy`=0. When `tx_vd`=1 is sampled, go to PRE. The byte is held by upstream, not consumed.
- **PRE:** 7 cycles; each loads 0x55 onto the PHY register. Then SFD.
- **SFD:** 1 cycle; loads 0xD5. Then DATA.
- **DATA:** `tx_rdy`=1.
  - On handshake: load `tx_dat`, update CRC, increment the 11-bit byte counter (saturates at 2047).
  - Handshake with `tx_last`:
    - count after increment < `MIN_LEN` → PAD.
    - otherwise → FCS.
  - Underrun (`tx_vd`=0 while in DATA): load `phy_tx_er`=1, `phy_tx_en`=1, `phy_txd`=0x00 for one byte; pulse `tx_underrun`; go to IFG with no FCS. Upstream discards the rest of that frame.
- **PAD:** load 0x00 and update CRC until count = `MIN_LEN`, then FCS.
- **FCS:** 4 cycles sending `~crc`, LSB byte first (`~crc[7:0]` first). Then IFG.
- **IFG:** `phy_tx_en`=0 for `IFG_CYCLES` cycles, then IDLE.
- **CRC-32:** polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF. Covers payload and pad only, not preamble/SFD.
- Length above 1514 bytes is not checked; upstream guarantees it.
- **Reset values:** all outputs 0; FSM IDLE; counters 0; CRC 0xFFFFFFFF.
- **Reset mid-frame:** outputs drop to 0 immediately (async). The frame is lost and upstream must resend it.

## Timing
- Edge E0: `tx_vd` is first sampled high in IDLE.
  - E1..E7: 0x55 on `phy_txd`, with `phy_tx_en`=1 from E1.
  - E8: 0xD5.
  - E9: first handshake, first data byte on `phy_txd`.
- Each accepted byte appears on `phy_txd` at the same edge as its handshake. Zero added bubbles while `tx_vd` stays high.
- Frame with N ≥ 60 bytes:
  - last data byte at E(8+N);
  - FCS at E(9+N)..E(12+N);
  - `phy_tx_en` falls at E(13+N);
  - next frame's `tx_vd` is sampled at the earliest at E(12+N+`IFG_CYCLES`).
- `tx_busy` is high from E0 through the last IFG cycle.
- `tx_rdy` is a combinational decode of state == DATA (registered state, no input dependency).

## Structure
- Shared package `eth_pkg` holds:
  - constants PREAMBLE=0x55, SFD=0xD5, CRC_INIT=0xFFFFFFFF, CRC_POLY=0x04C11DB7;
  - the FSM state encoding.
- Sub-module `crc32_d8`: byte-wide combinational next-CRC function plus register, with `init` and `en` inputs. It is reused by the RX FCS checker.

## Test plan
1. **CRC unit:** `crc32_d8` fed ASCII "123456789" → final `~crc` = 0xCBF43926.
2. **64-byte frame** (60 payload, incrementing 0x00..0x3B) → `phy_txd`:
   - 7×0x55, 0xD5 at E1..E8;
   - payload at E9..E68;
   - 4 FCS bytes matching the model, LSB first;
   - `phy_tx_en` low at E73;
   - no PAD.
3. **9-byte frame "123456789"** → 51 bytes of 0x00 pad, then FCS over 60 bytes matching the model; 72 total bytes with `phy_tx_en` high.
4. **Back-to-back frames** with `tx_vd` held high → exactly 12 cycles of `phy_tx_en`=0 between them; second preamble starts on schedule.
5. **Underrun:** `tx_vd` drops after byte 20 → one 0x00 byte with `phy_tx_er`=1, `tx_underrun` pulse, then `phy_tx_en`=0 with no FCS; the next frame is sent correctly.
6. **Reset mid-DATA:** `rst_n` low at byte 30 → all outputs 0 asynchronously, then a clean IDLE. A frame issued after reset is bit-exact.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, TX framer state encoding and the reflected CRC-32 byte step.
// Used by the GMII TX framer and the RX FCS checker.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE = 8'h55;
  localparam logic [7:0]  SFD      = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet sends LSB first, so the shift register runs right with the mirrored polynomial.
  localparam logic [31:0] CRC_POLY_REFL = bit_reverse32(CRC_POLY);

  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] dat);
    logic [31:0] c;
    c = crc ^ {24'h0, dat};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register: init reloads 0xFFFFFFFF, en folds in one byte.
// Output is the raw register; the caller inverts it for the FCS.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  dat,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc32_next(crc, dat);
  end

endmodule

// File: rtl/gmii_tx_outgoing.sv
// GMII transmit framer: preamble/SFD, zero pad to MIN_LEN, FCS append, IFG enforcement.
// Bytes go out on the registered PHY pins at the same edge they are accepted.
module gmii_tx_outgoing
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60
) (
  input  logic       clk_125m,
  input  logic       rst_n,
  input  logic [7:0] tx_dat,
  input  logic       tx_vd,
  input  logic       tx_last,
  output logic       tx_rdy,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       phy_tx_en,
  output logic       phy_tx_er,
  output logic [7:0] phy_txd
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
  // IDLE supplies the final idle cycle, so IFG itself spans IFG_CYCLES-1 cycles.
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 2);

  tx_state_t   state, state_n;
  logic [7:0]  sub_cnt, sub_n;
  logic [10:0] byte_cnt, cnt_n, cnt_inc;
  logic        en_n, er_n, und_n;
  logic [7:0]  txd_n;
  logic        crc_init, crc_en;
  logic [31:0] crc, fcs;

  assign tx_rdy  = (state == ST_DATA);
  assign tx_busy = (state != ST_IDLE);
  assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign fcs     = ~crc;

  crc32_d8 u_crc (
    .clk   (clk_125m),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .dat   (txd_n),
    .crc   (crc)
  );

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sub_cnt     <= '0;
      byte_cnt    <= '0;
      phy_tx_en   <= 1'b0;
      phy_tx_er   <= 1'b0;
      phy_txd     <= '0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_n;
      sub_cnt     <= sub_n;
      byte_cnt    <= cnt_n;
      phy_tx_en   <= en_n;
      phy_tx_er   <= er_n;
      phy_txd     <= txd_n;
      tx_underrun <= und_n;
    end
  end

  always_comb begin
    state_n  = state;
    sub_n    = sub_cnt;
    cnt_n    = byte_cnt;
    en_n     = 1'b0;
    er_n     = 1'b0;
    txd_n    = 8'h00;
    und_n    = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        crc_init = 1'b1;
        cnt_n    = '0;
        sub_n    = '0;
        if (tx_vd) state_n = ST_PRE;
      end
      ST_PRE: begin
        en_n  = 1'b1;
        txd_n = PREAMBLE;
        if (sub_cnt == 8'd6) begin
          sub_n   = '0;
          state_n = ST_SFD;
        end else begin
          sub_n = sub_cnt + 8'd1;
        end
      end
      ST_SFD: begin
        en_n    = 1'b1;
        txd_n   = SFD;
        state_n = ST_DATA;
      end
      ST_DATA: begin
        en_n = 1'b1;
        if (tx_vd) begin
          txd_n  = tx_dat;
          crc_en = 1'b1;
          cnt_n  = cnt_inc;
          if (tx_last) state_n = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
        end else begin
          // Upstream starved mid-frame: poison the byte with TX_ER and skip the FCS.
          er_n    = 1'b1;
          und_n   = 1'b1;
          sub_n   = '0;
          state_n = ST_IFG;
        end
      end
      ST_PAD: begin
        en_n   = 1'b1;
        crc_en = 1'b1;
        cnt_n  = cnt_inc;
        if (cnt_inc >= MIN_CNT) state_n = ST_FCS;
      end
      ST_FCS: begin
        en_n = 1'b1;
        case (sub_cnt[1:0])
          2'd0:    txd_n = fcs[7:0];
          2'd1:    txd_n = fcs[15:8];
          2'd2:    txd_n = fcs[23:16];
          default: txd_n = fcs[31:24];
        endcase
        if (sub_cnt[1:0] == 2'd3) begin
          sub_n   = '0;
          state_n = ST_IFG;
        end else begin
          sub_n = sub_cnt + 8'd1;
        end
      end
      ST_IFG: begin
        if (sub_cnt >= IFG_LAST) begin
          sub_n   = '0;
          state_n = ST_IDLE;
        end else begin
          sub_n = sub_cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gmii_tx_outgoing.sv
// Scoreboarded bench for the GMII TX framer and its CRC-32 sub-block.
module tb_gmii_tx_outgoing;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_dat;
  logic       tx_vd;
  logic       tx_last;
  logic       tx_rdy;
  logic       tx_busy;
  logic       tx_underrun;
  logic       phy_tx_en;
  logic       phy_tx_er;
  logic [7:0] phy_txd;

  logic        c_init, c_en;
  logic [7:0]  c_dat;
  logic [31:0] c_crc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pay_q[$];
  int         len_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int         gap_q[$];
  int         start_q[$];
  int         cyc_first_en, last_en_cyc, und_cnt, und_cyc;
  bit         timed_out;

  gmii_tx_outgoing #(.IFG_CYCLES(12), .MIN_LEN(60)) dut (
    .clk_125m    (clk),
    .rst_n       (rst_n),
    .tx_dat      (tx_dat),
    .tx_vd       (tx_vd),
    .tx_last     (tx_last),
    .tx_rdy      (tx_rdy),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun),
    .phy_tx_en   (phy_tx_en),
    .phy_tx_er   (phy_tx_er),
    .phy_txd     (phy_txd)
  );

  crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (c_init),
    .en    (c_en),
    .dat   (c_dat),
    .crc   (c_crc)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // Bit-serial reference CRC, LSB of each byte first.
  function automatic logic [31:0] model_crc(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  // Expected wire image {er, txd} of one frame; cut >= 0 models an underrun after cut bytes.
  task automatic push_frame(input int start, input int len, input int cut);
    logic [31:0] crc, fcs;
    int n;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    crc = 32'hFFFF_FFFF;
    n = (cut >= 0) ? cut : len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, pay_q[start+i]});
      crc = model_crc(crc, pay_q[start+i]);
    end
    if (cut >= 0) begin
      exp_q.push_back({1'b1, 8'h00});
      return;
    end
    for (int i = len; i < 60; i++) begin
      exp_q.push_back({1'b0, 8'h00});
      crc = model_crc(crc, 8'h00);
    end
    fcs = ~crc;
    for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, fcs[8*b +: 8]});
  endtask

  task automatic set_inputs(input int idx, input int fidx, input int pos, input int under_after);
    if (fidx < len_q.size() && !(under_after >= 0 && fidx == 0 && pos >= under_after)) begin
      tx_vd   = 1'b1;
      tx_dat  = pay_q[idx];
      tx_last = (pos == len_q[fidx] - 1);
    end else begin
      tx_vd   = 1'b0;
      tx_dat  = 8'h00;
      tx_last = 1'b0;
    end
  endtask

  // Upstream model plus wire monitor; cycle 0 is the edge that first samples tx_vd (E0).
  task automatic drive(input int under_after, input int stop_at);
    int idx, fidx, pos, cyc, gap;
    bit hs, seen_en, done;
    idx = 0; fidx = 0; pos = 0; cyc = -1; gap = 0; seen_en = 0; done = 0;
    obs_q.delete(); gap_q.delete(); start_q.delete();
    cyc_first_en = -1; last_en_cyc = -1; und_cnt = 0; und_cyc = -1; timed_out = 0;
    set_inputs(idx, fidx, pos, under_after);
    while (!done) begin
      hs = tx_vd && tx_rdy;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        idx++; pos++;
        if (pos == len_q[fidx]) begin fidx++; pos = 0; end
      end
      if (phy_tx_en) begin
        obs_q.push_back({phy_tx_er, phy_txd});
        if (!seen_en || gap > 0) start_q.push_back(cyc);
        if (seen_en && gap > 0) gap_q.push_back(gap);
        gap = 0; seen_en = 1; last_en_cyc = cyc;
        if (cyc_first_en < 0) cyc_first_en = cyc;
      end else if (seen_en) begin
        gap++;
      end
      if (tx_underrun) begin
        und_cnt++; und_cyc = cyc;
        if (fidx == 0 && under_after >= 0) begin
          idx += len_q[0] - pos; fidx = 1; pos = 0;
        end
      end
      if (stop_at >= 0 && idx >= stop_at) return;
      if (fidx >= len_q.size() && seen_en && !phy_tx_en && !tx_busy) done = 1;
      else if (cyc >= 3000) begin timed_out = 1; done = 1; end
      set_inputs(idx, fidx, pos, under_after);
    end
    set_inputs(0, len_q.size(), 0, -1);
  endtask

  task automatic clear_frames();
    pay_q.delete(); len_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_vd = 1'b0; tx_dat = 8'h00; tx_last = 1'b0;
    c_init = 1'b0; c_en = 1'b0; c_dat = 8'h00;
    #20;
    n_tests++; if (phy_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", phy_tx_en); end
    n_tests++; if (phy_tx_er !== 1'b0) begin n_fail++; $display("FAIL reset_er got %b want 0", phy_tx_er); end
    n_tests++; if (phy_txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd got %h want 00", phy_txd); end
    n_tests++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", tx_rdy); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    n_tests++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b want 0", tx_underrun); end
    n_tests++; if (c_crc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_crc got %h want ffffffff", c_crc); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_crc_unit();
    string s;
    logic [31:0] m;
    s = "123456789";
    c_init = 1'b1;
    @(posedge clk); #1;
    c_init = 1'b0;
    n_tests++; if (c_crc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL crc_init got %h want ffffffff", c_crc); end
    m = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      c_en = 1'b1; c_dat = s[i];
      m = model_crc(m, s[i]);
      @(posedge clk); #1;
    end
    c_en = 1'b0;
    n_tests++; if (~c_crc !== 32'hCBF4_3926) begin n_fail++; $display("FAIL crc_check got %h want cbf43926", ~c_crc); end
    n_tests++; if (~c_crc !== ~m) begin n_fail++; $display("FAIL crc_model got %h want %h", ~c_crc, ~m); end
  endtask

  task automatic compare_stream(input string name);
    logic [8:0] e, o;
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'bx;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s byte %0d got er=%b txd=%h want er=%b txd=%h", name, k, o[8], o[7:0], e[8], e[7:0]);
      end
      k++;
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL %s extra bytes got %0d want 0", name, obs_q.size()); end
  endtask

  task automatic test_frame64();
    clear_frames();
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(i));
    len_q.push_back(60);
    push_frame(0, 60, -1);
    drive(-1, -1);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL f64_timeout got %b want 0", timed_out); end
    n_tests++; if (cyc_first_en != 1) begin n_fail++; $display("FAIL f64_first_en got E%0d want E1", cyc_first_en); end
    n_tests++; if (obs_q.size() != 72) begin n_fail++; $display("FAIL f64_len got %0d want 72", obs_q.size()); end
    n_tests++; if (last_en_cyc + 1 != 73) begin n_fail++; $display("FAIL f64_en_fall got E%0d want E73", last_en_cyc + 1); end
    n_tests++; if (und_cnt != 0) begin n_fail++; $display("FAIL f64_underrun got %0d want 0", und_cnt); end
    compare_stream("f64");
  endtask

  task automatic test_short_pad();
    string s;
    s = "123456789";
    clear_frames();
    for (int i = 0; i < 9; i++) pay_q.push_back(s[i]);
    len_q.push_back(9);
    push_frame(0, 9, -1);
    drive(-1, -1);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL pad_timeout got %b want 0", timed_out); end
    n_tests++; if (obs_q.size() != 72) begin n_fail++; $display("FAIL pad_len got %0d want 72", obs_q.size()); end
    n_tests++; if (last_en_cyc != 72) begin n_fail++; $display("FAIL pad_last_en got E%0d want E72", last_en_cyc); end
    compare_stream("pad");
  endtask

  task automatic test_back_to_back();
    clear_frames();
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(i));
    for (int i = 0; i < 61; i++) pay_q.push_back(8'(8'hA0 + i));
    len_q.push_back(60);
    len_q.push_back(61);
    push_frame(0, 60, -1);
    push_frame(60, 61, -1);
    drive(-1, -1);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got %b want 0", timed_out); end
    n_tests++; if (gap_q.size() != 1) begin n_fail++; $display("FAIL b2b_gaps got %0d want 1", gap_q.size()); end
    n_tests++; if (gap_q.size() < 1 || gap_q[0] != 12) begin n_fail++; $display("FAIL b2b_ifg got %0d want 12", (gap_q.size() > 0) ? gap_q[0] : -1); end
    n_tests++; if (start_q.size() < 2 || start_q[1] != 85) begin n_fail++; $display("FAIL b2b_second_pre got E%0d want E85", (start_q.size() > 1) ? start_q[1] : -1); end
    compare_stream("b2b");
  endtask

  task automatic test_underrun();
    clear_frames();
    for (int i = 0; i < 40; i++) pay_q.push_back(8'(3 * i + 1));
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(8'h5A ^ i));
    len_q.push_back(40);
    len_q.push_back(60);
    push_frame(0, 40, 20);
    push_frame(40, 60, -1);
    drive(20, -1);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL und_timeout got %b want 0", timed_out); end
    n_tests++; if (und_cnt != 1) begin n_fail++; $display("FAIL und_pulses got %0d want 1", und_cnt); end
    n_tests++; if (und_cyc != 29) begin n_fail++; $display("FAIL und_edge got E%0d want E29", und_cyc); end
    n_tests++; if (gap_q.size() < 1 || gap_q[0] != 12) begin n_fail++; $display("FAIL und_ifg got %0d want 12", (gap_q.size() > 0) ? gap_q[0] : -1); end
    compare_stream("und");
  endtask

  task automatic test_reset_mid();
    clear_frames();
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(i + 7));
    len_q.push_back(60);
    drive(-1, 30);
    n_tests++; if (phy_tx_en !== 1'b1 || phy_txd !== 8'(29 + 7)) begin n_fail++; $display("FAIL rst_pre en=%b txd=%h want en=1 txd=%h", phy_tx_en, phy_txd, 8'(36)); end
    #1 rst_n = 1'b0;
    tx_vd = 1'b0; tx_last = 1'b0; tx_dat = 8'h00;
    #1;
    n_tests++; if ({phy_tx_en, phy_tx_er, phy_txd} !== 10'h000) begin n_fail++; $display("FAIL rst_async en=%b er=%b txd=%h want all 0", phy_tx_en, phy_tx_er, phy_txd); end
    n_tests++; if ({tx_rdy, tx_busy, tx_underrun} !== 3'b000) begin n_fail++; $display("FAIL rst_ctrl rdy=%b busy=%b und=%b want 000", tx_rdy, tx_busy, tx_underrun); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (tx_busy !== 1'b0 || phy_tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_idle busy=%b en=%b want 0 0", tx_busy, phy_tx_en); end
    clear_frames();
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(8'hFF - i));
    len_q.push_back(60);
    push_frame(0, 60, -1);
    drive(-1, -1);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rst_after_timeout got %b want 0", timed_out); end
    n_tests++; if (cyc_first_en != 1) begin n_fail++; $display("FAIL rst_after_first_en got E%0d want E1", cyc_first_en); end
    compare_stream("rst_after");
  endtask

  initial begin
    test_reset();
    test_crc_unit();
    test_frame64();
    test_short_pad();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
